// File: rtl/closed_loop_current_controller_v3.sv
// Closed-loop current-source controller: counts ring-oscillator edges per window and steps a thermometer enable.
// Optional lock detector compiled in with `define CSC_LOCK_DETECT_EN.
module closed_loop_current_controller_v3 #(
    parameter int N_SRC      = 32,
    parameter int CNT_W      = 8,
    parameter int WIN_W      = 12,
    parameter int INIT_SRC   = 16,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_WIN   = 3,
    parameter int SRC_W      = $clog2(N_SRC + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             OSC_IN,
    input  logic             LOOP_BYPASS,
    input  logic [SRC_W-1:0] BYPASS_SRC,
    input  logic [SRC_W-1:0] STEP,
    input  logic [WIN_W-1:0] WINDOW_CYCLES,
    input  logic [CNT_W-1:0] LOWER_BOUND,
    input  logic [CNT_W-1:0] UPPER_BOUND,
    output logic [N_SRC-1:0] CURRENT_SOURCE_ENABLE,
    output logic [SRC_W-1:0] ACTIVE_SRC,
    output logic [CNT_W-1:0] OSC_COUNT,
    output logic             COUNT_VALID,
    output logic             LOCKED
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        EVAL   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYC + 2);
    localparam logic [SRC_W:0]   N_SRC_X  = (SRC_W + 1)'(N_SRC);
    localparam logic [SRC_W-1:0] INIT_VAL = SRC_W'(INIT_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [N_SRC-1:0] thermo(input logic [SRC_W-1:0] n);
        logic [N_SRC-1:0] t;
        for (int i = 0; i < N_SRC; i++) begin
            t[i] = (n > SRC_W'(i));
        end
        return t;
    endfunction

    logic             sync1_r, sync2_r, sync3_r;
    logic             edge_s;
    state_t           state_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [WIN_W-1:0] timer_r;
    logic [SET_W-1:0] settle_cnt_r;
    logic [SRC_W-1:0] active_src_r;
    logic [N_SRC-1:0] enable_r;
    logic [CNT_W-1:0] osc_count_r;
    logic             count_valid_r;

    logic [SRC_W:0]   step_x_s, act_x_s, sum_x_s, next_src_s, bypass_src_s;
    logic             misconfig_s, below_s, above_s;

    // Oscillator synchroniser plus delay flop for rising-edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= OSC_IN;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~sync3_r;

    // Correction arithmetic, one bit wider than the source count so nothing wraps
    always_comb begin
        step_x_s     = (STEP == {SRC_W{1'b0}}) ? (SRC_W + 1)'(1) : {1'b0, STEP};
        act_x_s      = {1'b0, active_src_r};
        sum_x_s      = act_x_s + step_x_s;
        misconfig_s  = (LOWER_BOUND > UPPER_BOUND);
        below_s      = !misconfig_s && (edge_cnt_r < LOWER_BOUND);
        above_s      = !misconfig_s && (edge_cnt_r > UPPER_BOUND);
        next_src_s   = act_x_s;
        if (below_s) begin
            next_src_s = (sum_x_s > N_SRC_X) ? N_SRC_X : sum_x_s;
        end else if (above_s) begin
            next_src_s = (act_x_s > step_x_s) ? (act_x_s - step_x_s) : {(SRC_W + 1){1'b0}};
        end else begin
            next_src_s = act_x_s;
        end
        if ({1'b0, BYPASS_SRC} > N_SRC_X) begin
            bypass_src_s = N_SRC_X;
        end else begin
            bypass_src_s = {1'b0, BYPASS_SRC};
        end
    end

    // Measurement / correction FSM; bypass overrides every state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= IDLE;
            edge_cnt_r    <= {CNT_W{1'b0}};
            timer_r       <= {WIN_W{1'b0}};
            settle_cnt_r  <= {SET_W{1'b0}};
            active_src_r  <= INIT_VAL;
            osc_count_r   <= {CNT_W{1'b0}};
            count_valid_r <= 1'b0;
        end else if (LOOP_BYPASS) begin
            state_r       <= IDLE;
            edge_cnt_r    <= {CNT_W{1'b0}};
            active_src_r  <= bypass_src_s[SRC_W-1:0];
            count_valid_r <= 1'b0;
        end else begin
            count_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    edge_cnt_r <= {CNT_W{1'b0}};
                    timer_r    <= (WINDOW_CYCLES == {WIN_W{1'b0}}) ? WIN_W'(1) : WINDOW_CYCLES;
                    state_r    <= MEAS;
                end
                MEAS: begin
                    if (edge_s && (edge_cnt_r != CNT_MAX)) begin
                        edge_cnt_r <= edge_cnt_r + CNT_W'(1);
                    end
                    timer_r <= timer_r - WIN_W'(1);
                    if (timer_r <= WIN_W'(1)) begin
                        state_r <= EVAL;
                    end
                end
                EVAL: begin
                    osc_count_r   <= edge_cnt_r;
                    count_valid_r <= 1'b1;
                    active_src_r  <= next_src_s[SRC_W-1:0];
                    if (next_src_s != act_x_s) begin
                        settle_cnt_r <= SET_W'(SETTLE_CYC);
                        state_r      <= SETTLE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETTLE: begin
                    edge_cnt_r <= {CNT_W{1'b0}};
                    if (settle_cnt_r <= SET_W'(1)) begin
                        state_r <= IDLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - SET_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Thermometer enable trails active_src by one cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            enable_r <= thermo(INIT_VAL);
        end else begin
            enable_r <= thermo(active_src_r);
        end
    end

`ifdef CSC_LOCK_DETECT_EN
    localparam int LW = $clog2(LOCK_WIN + 1);
    logic [LW-1:0] lock_cnt_r;
    logic [LW-1:0] lock_inc_s;
    logic          locked_r;
    logic          in_band_s;

    assign in_band_s  = !misconfig_s && !below_s && !above_s;
    assign lock_inc_s = (lock_cnt_r == LW'(LOCK_WIN)) ? lock_cnt_r : (lock_cnt_r + LW'(1));

    // Consecutive in-band window counter; misconfigured bounds count as out of band
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_cnt_r <= {LW{1'b0}};
            locked_r   <= 1'b0;
        end else if (LOOP_BYPASS) begin
            lock_cnt_r <= {LW{1'b0}};
            locked_r   <= 1'b0;
        end else if (state_r == EVAL) begin
            if (in_band_s) begin
                lock_cnt_r <= lock_inc_s;
                locked_r   <= (lock_inc_s == LW'(LOCK_WIN));
            end else begin
                lock_cnt_r <= {LW{1'b0}};
                locked_r   <= 1'b0;
            end
        end else begin
            lock_cnt_r <= lock_cnt_r;
            locked_r   <= locked_r;
        end
    end

    assign LOCKED = locked_r;
`else
    assign LOCKED = 1'b0;
`endif

    assign CURRENT_SOURCE_ENABLE = enable_r;
    assign ACTIVE_SRC            = active_src_r;
    assign OSC_COUNT             = osc_count_r;
    assign COUNT_VALID           = count_valid_r;

endmodule
